seven_seg_scan_driver: RTL and testbench

- Consumes the tracker's four 5-bit digit codes (bcd3..bcd0) and its overflow flag (si).
- Drives a 4-digit common-anode seven-segment display by time-multiplexing: one digit is lit per slot, with a dead-time blanking interval at the start of each slot to suppress ghosting.
- Captures all inputs once per scan frame, so the digits shown within a frame always come from one consistent set of values.

---
 rtl/tracker_pkg.sv | 55 +++++
 rtl/seven_seg_scan_driver_seg_decoder.sv | 28 ++
 rtl/seven_seg_scan_driver.sv | 172 +++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/tracker_pkg.sv
// Shared definitions for the tracker display path: digit codes, segment
// patterns (active-low, {g,f,e,d,c,b,a}) and the scan digit index type.
package tracker_pkg;

    typedef logic [4:0] digit_code_t;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_idx_t;

    localparam digit_code_t CODE_UNDERSCORE = 5'h1F;

    localparam logic [6:0] SEG_BLANK      = 7'h7F;
    localparam logic [6:0] SEG_UNDERSCORE = 7'h77;
    localparam logic [6:0] SEG_0          = 7'h40;
    localparam logic [6:0] SEG_1          = 7'h79;
    localparam logic [6:0] SEG_2          = 7'h24;
    localparam logic [6:0] SEG_3          = 7'h30;
    localparam logic [6:0] SEG_4          = 7'h19;
    localparam logic [6:0] SEG_5          = 7'h12;
    localparam logic [6:0] SEG_6          = 7'h02;
    localparam logic [6:0] SEG_7          = 7'h78;
    localparam logic [6:0] SEG_8          = 7'h00;
    localparam logic [6:0] SEG_9          = 7'h10;

    // Active-low one-hot anode pattern for a digit index (digit 3 is leftmost).
    function automatic logic [3:0] digit_anodes(input digit_idx_t idx);
        logic [3:0] an;
        case (idx)
            DIG3:    an = 4'b0111;
            DIG2:    an = 4'b1011;
            DIG1:    an = 4'b1101;
            DIG0:    an = 4'b1110;
            default: an = 4'b1111;
        endcase
        return an;
    endfunction

    // Scan order is 3 -> 2 -> 1 -> 0 -> 3.
    function automatic digit_idx_t next_digit(input digit_idx_t idx);
        digit_idx_t nxt;
        case (idx)
            DIG3:    nxt = DIG2;
            DIG2:    nxt = DIG1;
            DIG1:    nxt = DIG0;
            DIG0:    nxt = DIG3;
            default: nxt = DIG3;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_seg_decoder.sv
// Combinational digit-code to active-low seven-segment pattern decoder.
module seg_decoder
    import tracker_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    // Map decimal digits and the underscore code; every other code is dark.
    always_comb begin
        seg = SEG_BLANK;
        case (code)
            5'h00:           seg = SEG_0;
            5'h01:           seg = SEG_1;
            5'h02:           seg = SEG_2;
            5'h03:           seg = SEG_3;
            5'h04:           seg = SEG_4;
            5'h05:           seg = SEG_5;
            5'h06:           seg = SEG_6;
            5'h07:           seg = SEG_7;
            5'h08:           seg = SEG_8;
            5'h09:           seg = SEG_9;
            CODE_UNDERSCORE: seg = SEG_UNDERSCORE;
            default:         seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed common-anode display driver. Inputs are sampled
// once per frame so a frame never mixes old and new digit values; each slot
// begins with a blanking interval to suppress ghosting between digits.
module seven_seg_scan_driver
    import tracker_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter bit          LZB          = 1'b0
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [4:0] bcd3,
    input  logic [4:0] bcd2,
    input  logic [4:0] bcd1,
    input  logic [4:0] bcd0,
    input  logic       si,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       frame_tick
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    digit_idx_t       digit_q, digit_d;

    digit_code_t snap3_q, snap3_d;
    digit_code_t snap2_q, snap2_d;
    digit_code_t snap1_q, snap1_d;
    digit_code_t snap0_q, snap0_d;
    logic        snap_si_q, snap_si_d;

    logic [6:0] seg_q, seg_d;
    logic [3:0] an_q, an_d;
    logic       dp_q, dp_d;
    logic       frame_tick_q, frame_tick_d;

    logic        frame_start_s;
    logic        drive_s;
    logic        lz3_s, lz2_s, lz1_s;
    logic        lzb_blank_s;
    digit_code_t sel_code_s;
    logic [6:0]  dec_seg_s;

    // Slot counter and digit index sequencing.
    always_comb begin
        slot_cnt_d = slot_cnt_q;
        digit_d    = digit_q;
        if (slot_cnt_q == SLOT_LAST) begin
            slot_cnt_d = '0;
            digit_d    = next_digit(digit_q);
        end else begin
            slot_cnt_d = slot_cnt_q + CNT_W'(1);
        end
    end

    // Frame snapshot: load all inputs at the start of digit 3's slot.
    always_comb begin
        frame_start_s = (digit_q == DIG3) && (slot_cnt_q == '0);
        snap3_d   = snap3_q;
        snap2_d   = snap2_q;
        snap1_d   = snap1_q;
        snap0_d   = snap0_q;
        snap_si_d = snap_si_q;
        if (frame_start_s) begin
            snap3_d   = bcd3;
            snap2_d   = bcd2;
            snap1_d   = bcd1;
            snap0_d   = bcd0;
            snap_si_d = si;
        end else begin
            snap3_d   = snap3_q;
        end
    end

    // Leading-zero chain from the left; any non-zero code stops it.
    always_comb begin
        lz3_s = LZB && (snap3_q == 5'h00);
        lz2_s = lz3_s && (snap2_q == 5'h00);
        lz1_s = lz2_s && (snap1_q == 5'h00);
    end

    // Select the code and blanking flag for the digit currently scanned.
    always_comb begin
        sel_code_s  = snap0_q;
        lzb_blank_s = 1'b0;
        case (digit_q)
            DIG3: begin
                sel_code_s  = snap3_q;
                lzb_blank_s = lz3_s;
            end
            DIG2: begin
                sel_code_s  = snap2_q;
                lzb_blank_s = lz2_s;
            end
            DIG1: begin
                sel_code_s  = snap1_q;
                lzb_blank_s = lz1_s;
            end
            DIG0: begin
                sel_code_s  = snap0_q;
                lzb_blank_s = 1'b0;
            end
            default: begin
                sel_code_s  = snap0_q;
                lzb_blank_s = 1'b0;
            end
        endcase
    end

    seg_decoder u_seg_decoder (
        .code (sel_code_s),
        .seg  (dec_seg_s)
    );

    // Output stage: blank phase keeps everything dark; drive phase lights one digit.
    always_comb begin
        drive_s      = (slot_cnt_q >= BLANK_LIM);
        an_d         = 4'hF;
        seg_d        = SEG_BLANK;
        dp_d         = 1'b1;
        frame_tick_d = frame_start_s;
        if (drive_s) begin
            an_d  = digit_anodes(digit_q);
            seg_d = lzb_blank_s ? SEG_BLANK : dec_seg_s;
            dp_d  = !((digit_q == DIG0) && snap_si_q);
        end else begin
            an_d  = 4'hF;
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end
    end

    // State, snapshot and registered output flops.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            slot_cnt_q   <= '0;
            digit_q      <= DIG3;
            snap3_q      <= 5'h00;
            snap2_q      <= 5'h00;
            snap1_q      <= 5'h00;
            snap0_q      <= 5'h00;
            snap_si_q    <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= 4'hF;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            digit_q      <= digit_d;
            snap3_q      <= snap3_d;
            snap2_q      <= snap2_d;
            snap1_q      <= snap1_d;
            snap0_q      <= snap0_d;
            snap_si_q    <= snap_si_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with REFRESH_DIV=8, BLANK_CYCLES=2.
// Two instances share the inputs: one without and one with leading-zero blanking.
module tb_seven_seg_scan_driver;

    logic       sys_clk;
    logic       reset;
    logic [4:0] bcd3, bcd2, bcd1, bcd0;
    logic       si;

    logic [6:0] seg0, seg1;
    logic [3:0] an0, an1;
    logic       dp0, dp1;
    logic       ft0, ft1;

    int checks = 0;
    int errors = 0;

    seven_seg_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .LZB(1'b0)) u_dut_nolzb (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .bcd3       (bcd3),
        .bcd2       (bcd2),
        .bcd1       (bcd1),
        .bcd0       (bcd0),
        .si         (si),
        .seg        (seg0),
        .an         (an0),
        .dp         (dp0),
        .frame_tick (ft0)
    );

    seven_seg_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .LZB(1'b1)) u_dut_lzb (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .bcd3       (bcd3),
        .bcd2       (bcd2),
        .bcd1       (bcd1),
        .bcd0       (bcd0),
        .si         (si),
        .seg        (seg1),
        .an         (an1),
        .dp         (dp1),
        .frame_tick (ft1)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " an0"},  {4'h0, an0},  8'h0F);
        chk({tag, " seg0"}, {1'b0, seg0}, 8'h7F);
        chk({tag, " dp0"},  {7'h00, dp0}, 8'h01);
        chk({tag, " ft0"},  {7'h00, ft0}, 8'h00);
        chk({tag, " an1"},  {4'h0, an1},  8'h0F);
        chk({tag, " ft1"},  {7'h00, ft1}, 8'h00);
    endtask

    // One 8-cycle slot of digit d: 2 blank cycles then 6 drive cycles.
    task automatic check_slot(input int d, input logic [6:0] s_nolzb,
                              input logic [6:0] s_lzb, input logic dp_drive);
        logic [3:0] an_exp;
        logic       blank;
        string      t;
        an_exp = ~(4'b0001 << d);
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            blank = (i < 2);
            t = $sformatf("d%0d c%0d", d, i);
            chk({t, " an0"},  {4'h0, an0},  blank ? 8'h0F : {4'h0, an_exp});
            chk({t, " an1"},  {4'h0, an1},  blank ? 8'h0F : {4'h0, an_exp});
            chk({t, " seg0"}, {1'b0, seg0}, blank ? 8'h7F : {1'b0, s_nolzb});
            chk({t, " seg1"}, {1'b0, seg1}, blank ? 8'h7F : {1'b0, s_lzb});
            chk({t, " dp0"},  {7'h00, dp0}, blank ? 8'h01 : {7'h00, dp_drive});
            chk({t, " ft0"},  {7'h00, ft0}, ((d == 3) && (i == 0)) ? 8'h01 : 8'h00);
            chk({t, " ft1"},  {7'h00, ft1}, ((d == 3) && (i == 0)) ? 8'h01 : 8'h00);
        end
    endtask

    task automatic set_codes(input logic [4:0] c3, input logic [4:0] c2,
                             input logic [4:0] c1, input logic [4:0] c0, input logic s);
        bcd3 = c3;
        bcd2 = c2;
        bcd1 = c1;
        bcd0 = c0;
        si   = s;
    endtask

    initial begin
        reset = 1'b1;
        set_codes(5'h01, 5'h02, 5'h03, 5'h04, 1'b0);
        #1 reset = 1'b0;

        // Held in reset.
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("reset_hold");

        // Release: first edge is the snapshot edge.
        reset = 1'b1;
        check_slot(3, 7'h79, 7'h79, 1'b1);
        check_slot(2, 7'h24, 7'h24, 1'b1);
        check_slot(1, 7'h30, 7'h30, 1'b1);
        check_slot(0, 7'h19, 7'h19, 1'b1);

        // Snapshot hold: bcd0 changes during digit 2's slot.
        check_slot(3, 7'h79, 7'h79, 1'b1);
        bcd0 = 5'h09;
        check_slot(2, 7'h24, 7'h24, 1'b1);
        check_slot(1, 7'h30, 7'h30, 1'b1);
        check_slot(0, 7'h19, 7'h19, 1'b1);
        check_slot(3, 7'h79, 7'h79, 1'b1);
        check_slot(2, 7'h24, 7'h24, 1'b1);
        check_slot(1, 7'h30, 7'h30, 1'b1);
        check_slot(0, 7'h10, 7'h10, 1'b1);

        // Distance format with underscore; LZB blanks the leading zero.
        set_codes(5'h00, 5'h03, 5'h1F, 5'h05, 1'b0);
        check_slot(3, 7'h40, 7'h7F, 1'b1);
        check_slot(2, 7'h30, 7'h30, 1'b1);
        check_slot(1, 7'h77, 7'h77, 1'b1);
        check_slot(0, 7'h12, 7'h12, 1'b1);

        // Overflow point on digit 0.
        set_codes(5'h09, 5'h09, 5'h09, 5'h09, 1'b1);
        check_slot(3, 7'h10, 7'h10, 1'b1);
        check_slot(2, 7'h10, 7'h10, 1'b1);
        check_slot(1, 7'h10, 7'h10, 1'b1);
        check_slot(0, 7'h10, 7'h10, 1'b0);

        // All zeros: LZB blanks digits 3..1, never digit 0.
        set_codes(5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
        check_slot(3, 7'h40, 7'h7F, 1'b1);
        check_slot(2, 7'h40, 7'h7F, 1'b1);
        check_slot(1, 7'h40, 7'h7F, 1'b1);
        check_slot(0, 7'h40, 7'h40, 1'b1);

        // Chain broken at digit 1.
        set_codes(5'h00, 5'h00, 5'h07, 5'h00, 1'b0);
        check_slot(3, 7'h40, 7'h7F, 1'b1);
        check_slot(2, 7'h40, 7'h7F, 1'b1);
        check_slot(1, 7'h78, 7'h78, 1'b1);
        check_slot(0, 7'h40, 7'h40, 1'b1);

        // Illegal codes are dark but break the LZB chain.
        set_codes(5'h0A, 5'h10, 5'h1E, 5'h00, 1'b0);
        check_slot(3, 7'h7F, 7'h7F, 1'b1);
        check_slot(2, 7'h7F, 7'h7F, 1'b1);
        check_slot(1, 7'h7F, 7'h7F, 1'b1);
        check_slot(0, 7'h40, 7'h40, 1'b1);

        // Asynchronous reset in the middle of digit 1's drive phase.
        check_slot(3, 7'h7F, 7'h7F, 1'b1);
        check_slot(2, 7'h7F, 7'h7F, 1'b1);
        repeat (4) @(negedge sys_clk);
        chk("pre_reset an0", {4'h0, an0}, 8'h0D);
        #2 reset = 1'b0;
        #1 check_reset_outputs("reset_async");
        repeat (2) @(negedge sys_clk);
        check_reset_outputs("reset_mid_hold");
        reset = 1'b1;
        check_slot(3, 7'h7F, 7'h7F, 1'b1);
        check_slot(2, 7'h7F, 7'h7F, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
